// File: rtl/nat_lookup_arbiter.sv
// Round-robin arbiter sharing one NAT lookup engine among NUM_CH channels, with in-order response return.
// Optional statistics counters are built only when NAT_ARB_STATS_EN is defined.
module nat_lookup_arbiter #(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned TUPLE_W = 128,
  parameter int unsigned CONN_W  = 16,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CH*TUPLE_W-1:0]   ch_tuple_data,
  input  logic [NUM_CH-1:0]           ch_tuple_valid,
  output logic [NUM_CH-1:0]           ch_tuple_ready,
  output logic [CONN_W-1:0]           ch_conn_data,
  output logic [NUM_CH-1:0]           ch_conn_valid,
  output logic [TUPLE_W-1:0]          lk_tuple_data,
  output logic                        lk_tuple_valid,
  input  logic                        lk_tuple_ready,
  input  logic [CONN_W-1:0]           lk_conn_data,
  input  logic                        lk_conn_valid,
  output logic                        resp_err,
  output logic [31:0]                 stat_grants,
  output logic [31:0]                 stat_stalls
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned PTR_W = $clog2(MAX_OUT);
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               slot_valid_q, slot_valid_d;
  logic [TUPLE_W-1:0] slot_data_q, slot_data_d;
  logic [IDX_W-1:0]   fifo_q [MAX_OUT];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NUM_CH-1:0]  conn_valid_q, conn_valid_d;
  logic [CONN_W-1:0]  conn_data_q, conn_data_d;
  logic               err_q, err_d;

  logic [NUM_CH-1:0]  req_rot;
  logic               win_found;
  logic [SUM_W-1:0]   win_off;
  logic [SUM_W-1:0]   win_sum;
  logic [SUM_W-1:0]   nxt_sum;
  logic [IDX_W-1:0]   win_idx;
  logic [TUPLE_W-1:0] win_data;
  logic               slot_free;
  logic               not_full;
  logic               grant;
  logic               pop;

  // Rotate requests so the search starts at rr_ptr; the lowest rotated set bit wins.
  always_comb begin
    req_rot   = NUM_CH'({ch_tuple_valid, ch_tuple_valid} >> rr_ptr_q);
    win_found = 1'b0;
    win_off   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_found = 1'b1;
        win_off   = SUM_W'(k);
      end
    end
    win_sum = SUM_W'(rr_ptr_q) + win_off;
    if (win_sum >= SUM_W'(NUM_CH)) begin
      win_sum = win_sum - SUM_W'(NUM_CH);
    end
    win_idx = win_sum[IDX_W-1:0];
    nxt_sum = win_sum + SUM_W'(1);
    if (nxt_sum >= SUM_W'(NUM_CH)) begin
      nxt_sum = '0;
    end
  end

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_data = ch_tuple_data[i*TUPLE_W +: TUPLE_W];
      end
    end
  end

  // Grant needs room in the output slot and below the outstanding limit (registered count only).
  always_comb begin
    slot_free = !slot_valid_q || lk_tuple_ready;
    not_full  = count_q < CNT_W'(MAX_OUT);
    grant     = reset && win_found && slot_free && not_full;
    pop       = lk_conn_valid && (count_q != '0);
  end

  always_comb begin
    ch_tuple_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_tuple_ready[i] = grant && (win_idx == IDX_W'(i));
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    conn_valid_d = '0;
    conn_data_d  = conn_data_q;
    err_d        = err_q;

    if (grant) begin
      rr_ptr_d     = nxt_sum[IDX_W-1:0];
      slot_valid_d = 1'b1;
      slot_data_d  = win_data;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
    end else if (lk_tuple_ready) begin
      slot_valid_d = 1'b0;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      conn_data_d = lk_conn_data;
      for (int i = 0; i < NUM_CH; i++) begin
        conn_valid_d[i] = (fifo_q[rd_ptr_q] == IDX_W'(i));
      end
    end

    case ({grant, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (lk_conn_valid && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      conn_valid_q <= '0;
      conn_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      conn_valid_q <= conn_valid_d;
      conn_data_q  <= conn_data_d;
      err_q        <= err_d;
    end
  end

  // Order FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      fifo_q[wr_ptr_q] <= win_idx;
    end
  end

  assign lk_tuple_valid = slot_valid_q;
  assign lk_tuple_data  = slot_data_q;
  assign ch_conn_valid  = conn_valid_q;
  assign ch_conn_data   = conn_data_q;
  assign resp_err       = err_q;

`ifdef NAT_ARB_STATS_EN
  logic [31:0] grants_q, grants_d;
  logic [31:0] stalls_q, stalls_d;
  logic        stall;

  always_comb begin
    stall    = (|ch_tuple_valid) && !grant;
    grants_d = grants_q;
    stalls_d = stalls_q;
    if (grant && (grants_q != '1)) begin
      grants_d = grants_q + 32'd1;
    end
    if (stall && (stalls_q != '1)) begin
      stalls_d = stalls_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_stalls = stalls_q;
`else
  assign stat_grants = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_nat_lookup_arbiter.sv
// Randomized bench for nat_lookup_arbiter against a queue-based transaction model.
module tb_nat_lookup_arbiter;

  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned TUPLE_W = 128;
  localparam int unsigned CONN_W  = 16;
  localparam int unsigned MAX_OUT = 4;

  logic                      clk;
  logic                      reset;
  logic [NUM_CH*TUPLE_W-1:0] ch_tuple_data;
  logic [NUM_CH-1:0]         ch_tuple_valid;
  logic [NUM_CH-1:0]         ch_tuple_ready;
  logic [CONN_W-1:0]         ch_conn_data;
  logic [NUM_CH-1:0]         ch_conn_valid;
  logic [TUPLE_W-1:0]        lk_tuple_data;
  logic                      lk_tuple_valid;
  logic                      lk_tuple_ready;
  logic [CONN_W-1:0]         lk_conn_data;
  logic                      lk_conn_valid;
  logic                      resp_err;
  logic [31:0]               stat_grants;
  logic [31:0]               stat_stalls;

  nat_lookup_arbiter #(
    .NUM_CH (NUM_CH),
    .TUPLE_W(TUPLE_W),
    .CONN_W (CONN_W),
    .MAX_OUT(MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ch_tuple_data (ch_tuple_data),
    .ch_tuple_valid(ch_tuple_valid),
    .ch_tuple_ready(ch_tuple_ready),
    .ch_conn_data  (ch_conn_data),
    .ch_conn_valid (ch_conn_valid),
    .lk_tuple_data (lk_tuple_data),
    .lk_tuple_valid(lk_tuple_valid),
    .lk_tuple_ready(lk_tuple_ready),
    .lk_conn_data  (lk_conn_data),
    .lk_conn_valid (lk_conn_valid),
    .resp_err      (resp_err),
    .stat_grants   (stat_grants),
    .stat_stalls   (stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Transaction-level model: outstanding channels in a queue, slot as valid+data.
  bit                 m_slot_v = 1'b0;
  logic [TUPLE_W-1:0] m_slot_d = '0;
  int                 m_q[$];
  int                 m_rr     = 0;
  bit                 m_err    = 1'b0;
  logic [NUM_CH-1:0]  m_cv     = '0;
  logic [CONN_W-1:0]  m_cd     = '0;
  longint             m_sg     = 0;
  longint             m_ss     = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input bit rst_n_v, input int p_valid, input int p_rdy, input int p_resp);
    logic [TUPLE_W-1:0] t;
    logic [NUM_CH-1:0]  exp_rdy;
    bit                 can, grant, pop;
    int                 w, qsz, id;
    @(negedge clk);
    reset = rst_n_v;
    for (int i = 0; i < NUM_CH; i++) begin
      t = '0;
      for (int c = 0; c < (TUPLE_W + 31) / 32; c++) begin
        t = (t << 32) | TUPLE_W'($urandom());
      end
      ch_tuple_data[i*TUPLE_W +: TUPLE_W] = t;
      ch_tuple_valid[i] = ($urandom_range(99) < p_valid);
    end
    lk_tuple_ready = ($urandom_range(99) < p_rdy);
    lk_conn_valid  = ($urandom_range(99) < p_resp);
    lk_conn_data   = CONN_W'($urandom());
    #1;

    qsz   = m_q.size();
    can   = rst_n_v && (!m_slot_v || lk_tuple_ready) && (qsz < MAX_OUT);
    grant = 1'b0;
    w     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      int c;
      c = (m_rr + k) % NUM_CH;
      if (!grant && can && ch_tuple_valid[c]) begin
        grant = 1'b1;
        w     = c;
      end
    end
    exp_rdy = '0;
    if (grant) exp_rdy[w] = 1'b1;
    check_eq("ch_tuple_ready", ch_tuple_ready, exp_rdy);

    if (!rst_n_v) begin
      m_slot_v = 1'b0;
      m_slot_d = '0;
      m_q.delete();
      m_rr  = 0;
      m_err = 1'b0;
      m_cv  = '0;
      m_cd  = '0;
      m_sg  = 0;
      m_ss  = 0;
    end else begin
      pop = lk_conn_valid && (qsz > 0);
      m_cv = '0;
      if (pop) begin
        id = m_q.pop_front();
        m_cv[id] = 1'b1;
        m_cd = lk_conn_data;
      end
      if (lk_conn_valid && qsz == 0) m_err = 1'b1;
      if (grant) begin
        m_slot_v = 1'b1;
        m_slot_d = ch_tuple_data[w*TUPLE_W +: TUPLE_W];
        m_q.push_back(w);
        m_rr = (w + 1) % NUM_CH;
      end else if (lk_tuple_ready) begin
        m_slot_v = 1'b0;
      end
`ifdef NAT_ARB_STATS_EN
      if (grant && m_sg < 64'hFFFFFFFF) m_sg++;
      if ((|ch_tuple_valid) && !grant && m_ss < 64'hFFFFFFFF) m_ss++;
`endif
    end

    @(posedge clk);
    #1;
    check_eq("lk_tuple_valid", lk_tuple_valid, m_slot_v);
    if (m_slot_v || !rst_n_v) check_eq("lk_tuple_data", lk_tuple_data, m_slot_d);
    check_eq("ch_conn_valid", ch_conn_valid, m_cv);
    if ((|m_cv) || !rst_n_v) check_eq("ch_conn_data", ch_conn_data, m_cd);
    check_eq("resp_err", resp_err, m_err);
    check_eq("stat_grants", stat_grants, m_sg[31:0]);
    check_eq("stat_stalls", stat_stalls, m_ss[31:0]);
  endtask

  initial begin
    reset          = 1'b0;
    ch_tuple_data  = '0;
    ch_tuple_valid = '0;
    lk_tuple_ready = 1'b0;
    lk_conn_valid  = 1'b0;
    lk_conn_data   = '0;

    for (int r = 0; r < 3; r++) step(1'b0, 50, 50, 50);
    for (int rep = 0; rep < 4; rep++) begin
      // Fully loaded traffic with prompt responses.
      for (int n = 0; n < 150; n++) step(1'b1, 100, 100, 35);
      // Rare responses: outstanding limit is hit repeatedly.
      for (int n = 0; n < 80; n++) step(1'b1, 80, 90, 6);
      // Heavy backpressure on the lookup request port.
      for (int n = 0; n < 80; n++) step(1'b1, 70, 15, 30);
      // Sparse requests with frequent responses provoke stray-response errors.
      for (int n = 0; n < 60; n++) step(1'b1, 10, 80, 50);
      // Mixed traffic, then reset mid-operation.
      for (int n = 0; n < 60; n++) step(1'b1, 60, 60, 20);
      for (int r = 0; r < 2; r++) step(1'b0, 80, 50, 40);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
